// File: rtl/vga_pkg.sv
// Shared VGA timing constants and paddle FSM encoding used by the paddle
// controller and its neighbours in the video pipeline.
package vga_pkg;

    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 783;
    localparam int PADDLE_W    = 170;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MOVE_L = 2'b01,
        MOVE_R = 2'b10
    } paddle_state_t;

    // Debounced buttons (bit0 = left, bit1 = right) to movement direction;
    // pressing both at once cancels out.
    function automatic paddle_state_t decode_buttons(input logic [1:0] pressed);
        case (pressed)
            2'b01:   return MOVE_L;
            2'b10:   return MOVE_R;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce for one active-low board key.
// The output is active-high and changes only after a stable run of DEBOUNCE_CYCLES.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, which keeps sync1 -> sync2 a real two-stage chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            state <= 1'b0;
        end else begin
            sync1 <= ~btn;
            sync2 <= sync1;
            if (sync2 == state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                state <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: debounced buttons drive a per-frame move of the
// paddle's right edge, ramping from a slow to a fast step and clamped to the screen.
module paddle_ctrl
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int X_MIN           = H_VIS_START + PADDLE_W - 1,
    parameter int X_MAX           = H_VIS_END,
    parameter int X_RESET         = 548,
    parameter int Y_POS           = 509,
    parameter int STEP_SLOW       = 2,
    parameter int STEP_FAST       = 6,
    parameter int ACCEL_FRAMES    = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  btn,
    input  logic [9:0]  v_counter,
    output logic [10:0] mem_X,
    output logic [10:0] mem_Y,
    output logic        frame_tick,
    output logic [1:0]  btn_state
);

    localparam int HW = $clog2(ACCEL_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(ACCEL_FRAMES);
    localparam logic [11:0]   MIN12    = 12'(X_MIN);
    localparam logic [11:0]   MAX12    = 12'(X_MAX);
    localparam logic [11:0]   SLOW12   = 12'(STEP_SLOW);
    localparam logic [11:0]   FAST12   = 12'(STEP_FAST);

    paddle_state_t state, next_state;
    logic [HW-1:0] hold, hold_base, next_hold;
    logic [10:0]   next_x;
    logic [11:0]   step, sum_l, sum_r;
    logic [9:0]    v_prev;

    for (genvar i = 0; i < 2; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .btn   (btn[i]),
            .state (btn_state[i])
        );
    end

    assign mem_Y = 11'(Y_POS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_prev     <= '0;
            frame_tick <= 1'b0;
            state      <= IDLE;
            hold       <= '0;
            mem_X      <= 11'(X_RESET);
        end else begin
            v_prev     <= v_counter;
            frame_tick <= (v_prev != '0) && (v_counter == '0);
            state      <= next_state;
            hold       <= next_hold;
            mem_X      <= next_x;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state = decode_buttons(btn_state);
        // A direction change restarts the ramp on the same cycle it is seen.
        hold_base  = (next_state != state) ? '0 : hold;
        step       = (hold_base < HOLD_SAT) ? SLOW12 : FAST12;
        sum_l      = {1'b0, mem_X} - step;
        sum_r      = {1'b0, mem_X} + step;
        next_x     = mem_X;
        next_hold  = hold_base;

        if (next_state == IDLE) begin
            next_hold = '0;
        end else if (frame_tick) begin
            next_hold = (hold_base < HOLD_SAT) ? hold_base + HW'(1) : hold_base;
            if (next_state == MOVE_L) begin
                next_x = (sum_l[11] || sum_l < MIN12) ? MIN12[10:0] : sum_l[10:0];
            end else begin
                next_x = (sum_r > MAX12) ? MAX12[10:0] : sum_r[10:0];
            end
        end
    end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Upstream of the VGA colour stage. Turns the two raw board buttons into the paddle position (mem_X, mem_Y) that the colour stage uses to draw the paddle.
- Synchronises and debounces the buttons and detects frame boundaries from the sync generator's v_counter.
- Moves the paddle once per frame, ramping from a slow to a fast step while a button is held, and clamps the position to the visible area.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable clk cycles before a button change is accepted (5 ms at 50 MHz).
- X_MIN, 313: lowest legal mem_X (right edge of paddle; paddle spans mem_X-169..mem_X).
- X_MAX, 783: highest legal mem_X.
- X_RESET, 548: mem_X after reset.
- Y_POS, 509: constant paddle row driven on mem_Y.
- STEP_SLOW, 2: pixels per frame during the first ACCEL_FRAMES frames of a hold.
- STEP_FAST, 6: pixels per frame after that.
- ACCEL_FRAMES, 15: number of slow-step frames before switching to STEP_FAST.

Ports:
- clk  in  1  system/pixel clock, same domain as the sync generator.
- reset  in  1  asynchronous, active-low reset.
- btn  in  2  raw board keys, active-low; btn[0]=move left, btn[1]=move right.
- v_counter  in  10  vertical counter from the sync generator.
- mem_X  out  11  paddle right-edge x coordinate.
- mem_Y  out  11  paddle row, always Y_POS.
- frame_tick  out  1  one-cycle strobe at each frame start.
- btn_state  out  2  debounced buttons, active-high (1 = pressed).

Behaviour:
- Reset (reset=0, asynchronous): mem_X=X_RESET, mem_Y=Y_POS, frame_tick=0, btn_state=0, debounce counters=0, FSM=IDLE, hold counter=0. All registers recover on the first clk edge after reset rises.
- Button synchroniser: each bit passes through a 2-flop synchroniser and is inverted to active-high.
- Debounce, per bit: a counter runs while the synchronised value differs from btn_state, and clears to 0 whenever the two match.
  - When the counter reaches DEBOUNCE_CYCLES-1, btn_state takes the new value and the counter clears.
  - Latency from raw edge to btn_state: 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_state.
- Frame tick: v_counter is registered as v_prev. frame_tick=1 for exactly one cycle when v_prev!=0 and v_counter==0.
  - Holding v_counter at 0 produces no further ticks.
  - The first tick after reset requires a non-zero-to-zero transition.
- FSM states: IDLE, MOVE_L, MOVE_R. Transitions are evaluated every cycle from btn_state:
  - left only -> MOVE_L.
  - right only -> MOVE_R.
  - none or both -> IDLE.
  - Any state change, including MOVE_L to MOVE_R directly, clears the hold counter.
- Movement happens only on frame_tick cycles; mem_X updates on the clk edge ending the tick cycle.
  - step = STEP_SLOW if hold < ACCEL_FRAMES, else STEP_FAST.
  - hold increments each tick in MOVE_L/MOVE_R and saturates at ACCEL_FRAMES.
  - MOVE_L: mem_X = max(mem_X - step, X_MIN). The subtraction is done in 12 bits so it cannot wrap below 0.
  - MOVE_R: mem_X = min(mem_X + step, X_MAX). The addition is done in 12 bits.
  - IDLE: mem_X holds and hold=0.
- Simultaneous events:
  - A state change on a tick cycle: the tick uses the new state's direction with hold=0, i.e. STEP_SLOW.
  - A debounce update on a tick cycle: the FSM sees the old btn_state on that cycle.
- Invariant: X_MIN <= mem_X <= X_MAX at all times outside reset.
- Reset mid-movement: immediate return to X_RESET; no partial step is committed.

Decomposition:
- Shared package vga_pkg holds:
  - VGA timing constants (H_TOTAL=800, V_TOTAL=525, visible window 144..783) and PADDLE_W=170.
  - The 2-bit state encoding for IDLE, MOVE_L and MOVE_R.
- One natural sub-module, btn_debounce: synchroniser plus debounce for a single bit, parameterised by DEBOUNCE_CYCLES, instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, other parameters at default):
- Reset release, no buttons -> mem_X=548, mem_Y=509, btn_state=00; mem_X unchanged across 3 frame ticks.
- Raw btn[0] low for 3 cycles, then high -> btn_state stays 00. Held low for 6 cycles -> btn_state[0]=1 exactly 6 cycles after the raw edge.
- v_counter sequence 524, 0, 0, 1 -> exactly one frame_tick, on the cycle after v_counter becomes 0.
- Hold right for 20 ticks from 548 -> 15 ticks at +2 (reaches 578), then +6 per tick: 584, 590, 596, 602, 608.
- Hold left from mem_X=315 -> next tick gives 313. Further ticks stay 313; never below X_MIN, no wrap.
- Both buttons held -> IDLE, mem_X frozen. Switch left to right mid-hold -> first right tick is +2.
- Assert reset during MOVE_R with mem_X=700 -> mem_X=548 asynchronously; FSM=IDLE on release.
